// File: rtl/dma_frame_loader.sv
// Front end for the 5-row column line buffer: loads one frame from an AXI-Stream
// DMA source, then sweeps every window position and streams 40-bit columns out.
module dma_frame_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 48,
    parameter int IMG_H      = 48,
    parameter int WIN        = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [31:0]               s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    output logic                      buf_ce,
    output logic                      buf_we,
    output logic [11:0]               buf_addr,
    output logic [31:0]               buf_d,
    input  logic [WIN*DATA_WIDTH-1:0] buf_q,
    output logic                      col_valid,
    input  logic                      col_ready,
    output logic [WIN*DATA_WIDTH-1:0] col_data,
    output logic                      col_first,
    output logic                      col_last,
    output logic                      busy,
    output logic                      err_tlast
);

    localparam int WORDS = IMG_W * IMG_H / 4;
    localparam int WCW   = $clog2(WORDS);
    localparam int RW    = $clog2(IMG_H);
    localparam int CW    = $clog2(IMG_W);
    localparam logic [WCW-1:0] WCNT_LAST = WCW'(WORDS - 1);
    localparam logic [RW-1:0]  ROW_LAST  = RW'(IMG_H - WIN);
    localparam logic [CW-1:0]  COL_LAST  = CW'(IMG_W - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SWEEP, DRAIN} state_t;

    state_t         state;
    logic [WCW-1:0] wcnt;
    logic [RW-1:0]  row;
    logic [CW-1:0]  col;
    logic           handshake;
    logic           take_col;
    logic           word_last;
    logic           sweep_end;
    logic [11:0]    sweep_addr;

    // tready is gated by rst so the source never sees an accept in the reset cycle
    assign s_axis_tready = (state == LOAD) && !rst;
    assign handshake     = s_axis_tvalid && s_axis_tready;
    assign take_col      = (state == SWEEP) && (!col_valid || col_ready);
    assign word_last     = (wcnt == WCNT_LAST);
    assign sweep_end     = (row == ROW_LAST) && (col == COL_LAST);
    assign sweep_addr    = 12'(row) * 12'(IMG_W) + 12'(col);

    always_comb begin
        buf_ce   = 1'b0;
        buf_we   = 1'b0;
        buf_addr = '0;
        buf_d    = '0;
        if (!rst) begin
            if (handshake) begin
                buf_ce   = 1'b1;
                buf_we   = 1'b1;
                buf_addr = 12'({wcnt, 2'b00});
                buf_d    = s_axis_tdata;
            end else if (state == SWEEP) begin
                // address held through a stall keeps buf_q aligned with the pending load
                buf_ce   = 1'b1;
                buf_addr = sweep_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wcnt      <= '0;
            row       <= '0;
            col       <= '0;
            busy      <= 1'b0;
            err_tlast <= 1'b0;
            col_valid <= 1'b0;
            col_data  <= '0;
            col_first <= 1'b0;
            col_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD;
                        wcnt      <= '0;
                        row       <= '0;
                        col       <= '0;
                        err_tlast <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    if (handshake) begin
                        // tlast is only checked; the word count alone ends the frame
                        if (s_axis_tlast != word_last) err_tlast <= 1'b1;
                        if (word_last) begin
                            wcnt  <= '0;
                            state <= SWEEP;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                SWEEP: begin
                    if (take_col) begin
                        col_data  <= buf_q;
                        col_valid <= 1'b1;
                        col_first <= (col == '0);
                        col_last  <= sweep_end;
                        if (col == COL_LAST) begin
                            col <= '0;
                            row <= sweep_end ? '0 : row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        if (sweep_end) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (col_valid && col_ready) begin
                        col_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_frame_loader.sv
// Bench for dma_frame_loader: buffer model, frame/window reference model,
// control-vector table, randomized frame scenarios and reset corner cases.
module tb_dma_frame_loader;

    localparam int IMG_W = 48;
    localparam int IMG_H = 48;
    localparam int WIN   = 5;
    localparam int WORDS = IMG_W * IMG_H / 4;
    localparam int NCOLS = (IMG_H - WIN + 1) * IMG_W;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        col_ready = 1'b0;
    logic        s_axis_tready, buf_ce, buf_we, col_valid, col_first, col_last, busy, err_tlast;
    logic [11:0] buf_addr;
    logic [31:0] buf_d;
    logic [39:0] buf_q, col_data;

    always #5 clk = ~clk;

    dma_frame_loader dut (
        .clk(clk), .rst(rst), .start(start),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .buf_ce(buf_ce), .buf_we(buf_we), .buf_addr(buf_addr), .buf_d(buf_d), .buf_q(buf_q),
        .col_valid(col_valid), .col_ready(col_ready), .col_data(col_data),
        .col_first(col_first), .col_last(col_last), .busy(busy), .err_tlast(err_tlast)
    );

    // column buffer: byte-addressed, combinational 5-row column read
    logic [7:0] mem [0:4351];
    always @(posedge clk) begin
        if (buf_ce && buf_we) begin
            mem[int'(buf_addr)]     <= buf_d[31:24];
            mem[int'(buf_addr) + 1] <= buf_d[23:16];
            mem[int'(buf_addr) + 2] <= buf_d[15:8];
            mem[int'(buf_addr) + 3] <= buf_d[7:0];
        end
    end
    always_comb begin
        int a;
        a = int'(buf_addr);
        buf_q = {mem[a], mem[a + IMG_W], mem[a + 2*IMG_W], mem[a + 3*IMG_W], mem[a + 4*IMG_W]};
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] outs();
        return 96'({s_axis_tready, buf_ce, buf_we, buf_addr, buf_d, col_valid,
                    col_data, col_first, col_last, busy, err_tlast});
    endfunction

    // randomized downstream ready
    int rdy_pct = 100;
    initial forever begin
        @(posedge clk);
        #1;
        col_ready = ($urandom_range(99) < rdy_pct);
    end

    // monitor: captures writes and accepted columns, checks stall stability
    logic [43:0] wr_q [$];
    logic [41:0] col_q [$];
    int   cyc = 0, stall_bad = 0, last_acc_cyc = -1, busy_fall_cyc = -1;
    logic prev_stall = 1'b0, prev_busy = 1'b0;
    logic [41:0] prev_col = '0;
    initial forever begin
        @(negedge clk);
        cyc++;
        if (prev_stall && (!col_valid || {col_data, col_first, col_last} != prev_col)) stall_bad++;
        if (!rst && buf_ce && buf_we) wr_q.push_back({buf_addr, buf_d});
        if (!rst && col_valid && col_ready) begin
            col_q.push_back({col_data, col_first, col_last});
            if (col_last) last_acc_cyc = cyc;
        end
        if (prev_busy && !busy) busy_fall_cyc = cyc;
        prev_stall = !rst && col_valid && !col_ready;
        prev_col   = {col_data, col_first, col_last};
        prev_busy  = busy;
    end

    // reference model: the frame as bytes, windows computed directly from it
    logic [7:0]  fb [0:IMG_W*IMG_H-1];
    logic [41:0] exp_q [$];

    function automatic logic [31:0] word_of(input int w);
        return {fb[4*w], fb[4*w+1], fb[4*w+2], fb[4*w+3]};
    endfunction

    task automatic build_frame(input int fill);
        logic [39:0] v;
        for (int i = 0; i < IMG_W*IMG_H; i++) fb[i] = (fill == 0) ? 8'(i) : 8'($urandom);
        exp_q.delete();
        for (int r = 0; r <= IMG_H - WIN; r++)
            for (int c = 0; c < IMG_W; c++) begin
                v = '0;
                for (int k = 0; k < WIN; k++) v = {v[31:0], fb[(r + k)*IMG_W + c]};
                exp_q.push_back({v, 1'(c == 0), 1'(r == IMG_H - WIN && c == IMG_W - 1)});
            end
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("busy_after_start", 96'(busy), 96'(1));
        check("err_cleared_by_start", 96'(err_tlast), 96'(0));
        tick();
    endtask

    task automatic send_words(input int gap_pct, input int tlast_pos, output bit ok);
        bit hs;
        int n;
        ok = 1'b1;
        for (int w = 0; w < WORDS && ok; w++) begin
            while ($urandom_range(99) < gap_pct) begin
                s_axis_tvalid = 1'b0;
                tick();
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = word_of(w);
            s_axis_tlast  = (w == tlast_pos);
            hs = 1'b0;
            n  = 0;
            while (!hs && n < 1000) begin
                @(negedge clk);
                hs = s_axis_tready;
                if (hs && w == tlast_pos && w < WORDS - 1)
                    check("err_before_early_tlast", 96'(err_tlast), 96'(0));
                tick();
                n++;
            end
            if (!hs) begin
                check("load_accept_timeout", 96'(0), 96'(1));
                ok = 1'b0;
            end else if (w == tlast_pos && w < WORDS - 1) begin
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
                @(negedge clk);
                check("err_after_early_tlast", 96'(err_tlast), 96'(1));
                tick();
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_idle(input bit pulse);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20000 && !done; i++) begin
            start = pulse && (i == 40);
            @(negedge clk);
            if (!busy) done = 1'b1;
            tick();
        end
        start = 1'b0;
        check("sweep_done_timeout", 96'(done), 96'(1));
    endtask

    typedef struct {
        int   fill;
        int   gap_pct;
        int   rdy_pct;
        int   tlast_pos;
        bit   pulse;
        logic exp_err;
    } scn_t;

    task automatic run_frame(input scn_t s);
        bit ok;
        int bad;
        build_frame(s.fill);
        wr_q.delete();
        col_q.delete();
        stall_bad = 0;
        last_acc_cyc = -1;
        busy_fall_cyc = -1;
        rdy_pct = s.rdy_pct;
        start_frame();
        send_words(s.gap_pct, s.tlast_pos, ok);
        wait_idle(s.pulse);
        rdy_pct = 100;
        tick();
        check("write_count", 96'(wr_q.size()), 96'(WORDS));
        bad = 0;
        for (int i = 0; i < wr_q.size() && i < WORDS; i++)
            if (wr_q[i] !== {12'(4*i), word_of(i)}) bad++;
        check("write_content_mismatches", 96'(bad), 96'(0));
        check("col_count", 96'(col_q.size()), 96'(NCOLS));
        bad = 0;
        for (int i = 0; i < col_q.size() && i < NCOLS; i++)
            if (col_q[i] !== exp_q[i]) bad++;
        check("col_sequence_mismatches", 96'(bad), 96'(0));
        check("stall_hold_violations", 96'(stall_bad), 96'(0));
        check("busy_fall_after_last_accept", 96'(busy_fall_cyc - last_acc_cyc), 96'(1));
        check("err_tlast_final", 96'(err_tlast), 96'(s.exp_err));
        if (s.fill == 0 && wr_q.size() == WORDS && col_q.size() == NCOLS) begin
            check("first_write", 96'(wr_q[0]), 96'({12'd0, 32'h00010203}));
            check("last_write_addr", 96'(wr_q[WORDS-1][43:32]), 96'(2300));
            check("first_col", 96'(col_q[0]), 96'({40'h00306090C0, 1'b1, 1'b0}));
            check("last_col", 96'(col_q[NCOLS-1]), 96'({40'h3F6F9FCFFF, 1'b0, 1'b1}));
        end
    endtask

    typedef struct {
        logic        start;
        logic        tvalid;
        logic        tlast;
        logic [31:0] tdata;
        logic        exp_tready;
        logic        exp_ce;
        logic        exp_we;
        logic [11:0] exp_addr;
        logic [31:0] exp_d;
        logic        exp_busy;
    } vec_t;

    vec_t vec [9];
    scn_t scn [5];

    initial begin
        bit ok;
        vec[0] = '{1'b0, 1'b1, 1'b1, 32'hAAAAAAAA, 1'b0, 1'b0, 1'b0, 12'd0, 32'h0, 1'b0};
        vec[1] = '{1'b0, 1'b1, 1'b0, 32'h55555555, 1'b0, 1'b0, 1'b0, 12'd0, 32'h0, 1'b0};
        vec[2] = '{1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 12'd0, 32'h0, 1'b0};
        vec[3] = '{1'b1, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 12'd0, 32'h0, 1'b0};
        vec[4] = '{1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 12'd0, 32'h0, 1'b1};
        vec[5] = '{1'b0, 1'b1, 1'b0, 32'h11223344, 1'b1, 1'b1, 1'b1, 12'd0, 32'h11223344, 1'b1};
        vec[6] = '{1'b0, 1'b1, 1'b0, 32'h55667788, 1'b1, 1'b1, 1'b1, 12'd4, 32'h55667788, 1'b1};
        vec[7] = '{1'b1, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 12'd0, 32'h0, 1'b1};
        vec[8] = '{1'b0, 1'b1, 1'b1, 32'h99AABBCC, 1'b1, 1'b1, 1'b1, 12'd8, 32'h99AABBCC, 1'b1};

        scn[0] = '{0, 0,  100, 575, 1'b0, 1'b0};
        scn[1] = '{0, 30, 50,  575, 1'b0, 1'b0};
        scn[2] = '{1, 20, 50,  100, 1'b1, 1'b1};
        scn[3] = '{1, 50, 60,  575, 1'b1, 1'b0};
        scn[4] = '{1, 0,  70,  -1,  1'b0, 1'b1};

        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_state_outputs", outs(), 96'(0));
        tick();

        // idle ignores the stream, then start / load / start-ignored control vectors
        for (int i = 0; i < 9; i++) begin
            start         = vec[i].start;
            s_axis_tvalid = vec[i].tvalid;
            s_axis_tlast  = vec[i].tlast;
            s_axis_tdata  = vec[i].tdata;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  96'({s_axis_tready, buf_ce, buf_we, vec[i].exp_we ? buf_addr : 12'd0,
                       vec[i].exp_we ? buf_d : 32'd0, busy}),
                  96'({vec[i].exp_tready, vec[i].exp_ce, vec[i].exp_we, vec[i].exp_addr,
                       vec[i].exp_d, vec[i].exp_busy}));
            tick();
        end
        start = 1'b0;

        // reset mid-LOAD with tvalid high: no write in the reset cycle, everything cleared
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = $urandom;
        s_axis_tlast  = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("err_set_by_early_tlast", 96'(err_tlast), 96'(1));
        check("no_write_in_reset_cycle", 96'({buf_we, s_axis_tready}), 96'(0));
        tick();
        rst = 1'b0;
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        check("reset_mid_load_outputs", outs(), 96'(0));
        tick();

        for (int i = 0; i < 5; i++) run_frame(scn[i]);

        // reset mid-SWEEP drops the held column and returns to idle
        build_frame(1);
        rdy_pct = 50;
        start_frame();
        send_words(0, 575, ok);
        repeat (300) tick();
        check("col_valid_mid_sweep", 96'(col_valid), 96'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_mid_sweep_outputs", outs(), 96'(0));
        tick();
        rdy_pct = 100;
        run_frame(scn[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
